// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared constants and types for the IO peripheral slice
// Contents: IO slot addresses of the UART, status-byte bit positions,
// and the state enum shared by the UART transmit and receive FSMs.
package io_pkg;

  // Decoder slots occupied by the UART (data port, then status port).
  localparam logic [2:0] IO_SLOT_UART_DATA = 3'd4;
  localparam logic [2:0] IO_SLOT_UART_STAT = 3'd5;

  // Bit positions inside the UART status byte.
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_FRAME_ERR  = 5;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

endpackage

// File: rtl/io_uart_if.sv
// rtl/io_uart_if.sv - strobe and serial-line bundle between CPU side and UART
// Signals: wr_data_stb / wr_stat_stb / rd_data_stb decoder strobes,
// rxd serial input, txd serial output, irq interrupt request.
// master = CPU/board side, slave = the UART.
interface io_uart_if;
  logic wr_data_stb;
  logic wr_stat_stb;
  logic rd_data_stb;
  logic rxd;
  logic txd;
  logic irq;

  modport master (
    output wr_data_stb, wr_stat_stb, rd_data_stb, rxd,
    input  txd, irq
  );

  modport slave (
    input  wr_data_stb, wr_stat_stb, rd_data_stb, rxd,
    output txd, irq
  );
endinterface

// File: rtl/io_sync_fifo.sv
// rtl/io_sync_fifo.sv - single-clock FIFO with first-word fall-through read
// Ports: clk, rst_n (sync, active-low), push/din write side, pop/dout read
// side (dout valid whenever !empty), full, empty, count (0..DEPTH).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/io_uart.sv
// rtl/io_uart.sv - 8N1 UART on two IO decoder slots (data port, status port)
// Ports: clk, rst_n (sync, active-low); bus (io_uart_if.slave: decoder
// strobes, rxd, txd, irq); io_data (data slot bus: write = TX byte, read =
// last RX byte); io_stat (status slot bus: read = status, write = clear errors).
// Status byte: {2'b0, frame_err, tx_busy, rx_overrun, rx_valid, tx_empty, tx_full}.
module io_uart
  import io_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  io_uart_if.slave   bus,
  inout  wire  [7:0] io_data,
  inout  wire  [7:0] io_stat
);

  localparam int             TW     = $clog2(CLK_DIV);
  localparam int             CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]  T_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]  T_HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);

  // Strobe edge detect: a held strobe acts only on its first cycle.
  logic wr_data_q, wr_stat_q, rd_data_q;
  logic wr_data_edge, wr_stat_edge, rd_data_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_data_q <= 1'b0;
      wr_stat_q <= 1'b0;
      rd_data_q <= 1'b0;
    end else begin
      wr_data_q <= bus.wr_data_stb;
      wr_stat_q <= bus.wr_stat_stb;
      rd_data_q <= bus.rd_data_stb;
    end
  end

  assign wr_data_edge = bus.wr_data_stb & ~wr_data_q;
  assign wr_stat_edge = bus.wr_stat_stb & ~wr_stat_q;
  assign rd_data_edge = bus.rd_data_stb & ~rd_data_q;

  // ---------------- transmit path ----------------
  uart_state_t   tx_state;
  logic [TW-1:0] tx_tmr;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          txd_q;
  logic          tx_pop, tx_push, tx_full, tx_empty, tx_busy;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;

  // The FSM takes a byte when idle, or straight from the end of a stop bit.
  assign tx_pop  = !tx_empty && ((tx_state == UART_IDLE) ||
                                 (tx_state == UART_STOP && tx_tmr == T_LAST));
  assign tx_push = wr_data_edge && ((tx_count < DEPTH_C) || tx_pop);
  assign tx_busy = (tx_state != UART_IDLE);

  io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (io_data),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= UART_IDLE;
      tx_tmr   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (tx_state)
        UART_IDLE: begin
          if (tx_pop) begin
            tx_state <= UART_START;
            tx_tmr   <= '0;
            tx_shift <= tx_dout;
            txd_q    <= 1'b0;
          end
        end
        UART_START: begin
          if (tx_tmr == T_LAST) begin
            tx_tmr   <= '0;
            tx_idx   <= '0;
            tx_state <= UART_DATA;
            txd_q    <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
          end else begin
            tx_tmr <= tx_tmr + 1'b1;
          end
        end
        UART_DATA: begin
          if (tx_tmr == T_LAST) begin
            tx_tmr <= '0;
            if (tx_idx == 3'd7) begin
              tx_state <= UART_STOP;
              txd_q    <= 1'b1;
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              txd_q    <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_tmr <= tx_tmr + 1'b1;
          end
        end
        UART_STOP: begin
          if (tx_tmr == T_LAST) begin
            tx_tmr <= '0;
            if (tx_pop) begin
              tx_state <= UART_START;
              tx_shift <= tx_dout;
              txd_q    <= 1'b0;
            end else begin
              tx_state <= UART_IDLE;
            end
          end else begin
            tx_tmr <= tx_tmr + 1'b1;
          end
        end
        default: tx_state <= UART_IDLE;
      endcase
    end
  end

  // ---------------- receive path ----------------
  logic          rx_s1, rx_s2;
  uart_state_t   rx_state;
  logic [TW-1:0] rx_tmr;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_data;
  logic          rx_valid, rx_overrun, frame_err;
  logic          stop_sample, rx_good, rx_bad, rx_deliver, rx_lost;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= bus.rxd;
      rx_s2 <= rx_s1;
    end
  end

  assign stop_sample = (rx_state == UART_STOP) && (rx_tmr == T_LAST);
  assign rx_good     = stop_sample && rx_s2;
  assign rx_bad      = stop_sample && !rx_s2;
  // A read landing on the same edge as a new byte makes room for it.
  assign rx_deliver  = rx_good && (!rx_valid || rd_data_edge);
  assign rx_lost     = rx_good && rx_valid && !rd_data_edge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state <= UART_IDLE;
      rx_tmr   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        UART_IDLE: begin
          if (!rx_s2) begin
            rx_state <= UART_START;
            rx_tmr   <= '0;
          end
        end
        UART_START: begin
          if (rx_tmr == T_HALF) begin
            rx_tmr   <= '0;
            rx_idx   <= '0;
            // Line back high at mid start bit: a glitch, not a frame.
            rx_state <= rx_s2 ? UART_IDLE : UART_DATA;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        UART_DATA: begin
          if (rx_tmr == T_LAST) begin
            rx_tmr   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= UART_STOP;
            else                rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        UART_STOP: begin
          if (rx_tmr == T_LAST) begin
            rx_tmr   <= '0;
            rx_state <= UART_IDLE;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        default: rx_state <= UART_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (rx_deliver) rx_data <= rx_shift;
      rx_valid   <= rx_deliver | (rx_valid & ~rd_data_edge);
      // A new error on the clearing edge keeps its flag set.
      rx_overrun <= rx_lost | (rx_overrun & ~wr_stat_edge);
      frame_err  <= rx_bad  | (frame_err  & ~wr_stat_edge);
    end
  end

  // ---------------- bus side ----------------
  logic [7:0] status;

  always_comb begin
    status                = 8'h00;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_VALID]   = rx_valid;
    status[ST_RX_OVERRUN] = rx_overrun;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_FRAME_ERR]  = frame_err;
  end

  assign io_data = bus.wr_data_stb ? 8'bz : rx_data;
  assign io_stat = bus.wr_stat_stb ? 8'bz : status;
  assign bus.txd = txd_q;
  assign bus.irq = rx_valid | rx_overrun | frame_err;

endmodule

// File: tb/tb_io_uart.sv
// tb/tb_io_uart.sv - self-checking bench for io_uart
module tb_io_uart;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_uart_if bus ();
  logic [7:0] tb_wdata = 8'h00;
  logic [7:0] tb_sdata = 8'h00;
  wire  [7:0] io_data;
  wire  [7:0] io_stat;

  assign io_data = bus.wr_data_stb ? tb_wdata : 8'bz;
  assign io_stat = bus.wr_stat_stb ? tb_sdata : 8'bz;

  io_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .io_data (io_data),
    .io_stat (io_stat)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // TX: queue of accepted bytes plus a per-cycle schedule of line levels.
  logic [7:0] mq[$];
  bit         sched[$];
  logic [9:0] m_frame;
  logic       m_txd = 1'b1, m_busy = 1'b0;
  logic       m_rx_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_rx_data = 8'h00;
  logic       pw = 1'b0, pr = 1'b0, ps = 1'b0;
  int         frames = 0;
  bit         rx_active = 1'b0;
  bit         chk_en = 1'b0;
  bit         full_seen = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      sched.delete();
      m_txd = 1'b1; m_busy = 1'b0;
      m_rx_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_rx_data = 8'h00;
      pw = 1'b0; pr = 1'b0; ps = 1'b0;
    end else begin
      if (sched.size() == 0 && mq.size() != 0) begin
        m_frame = {1'b1, mq.pop_front(), 1'b0};
        frames++;
        for (int i = 0; i < 10 * CLK_DIV; i++) sched.push_back(m_frame[i / CLK_DIV]);
      end
      if (bus.wr_data_stb && !pw && mq.size() < FIFO_DEPTH) mq.push_back(tb_wdata);
      m_busy = (sched.size() != 0);
      m_txd  = m_busy ? sched.pop_front() : 1'b1;
      if (bus.rd_data_stb && !pr) m_rx_valid = 1'b0;
      if (bus.wr_stat_stb && !ps) begin m_ovr = 1'b0; m_ferr = 1'b0; end
      pw = bus.wr_data_stb; pr = bus.rd_data_stb; ps = bus.wr_stat_stb;
    end
  end

  // Compare process: every cycle, away from the active edge.
  logic [7:0] m_stat;
  always @(negedge clk) begin
    if (chk_en) begin
      m_stat = {2'b00, m_ferr, m_busy, m_ovr, m_rx_valid,
                mq.size() == 0, mq.size() == FIFO_DEPTH};
      chk("txd", bus.txd, m_txd);
      if (!bus.wr_stat_stb) begin
        if (io_stat[0]) full_seen = 1'b1;
        if (rx_active) chk("status_tx", io_stat & 8'h13, m_stat & 8'h13);
        else           chk("status", io_stat, m_stat);
      end
      if (!rx_active) begin
        chk("irq", bus.irq, m_rx_valid | m_ovr | m_ferr);
        if (!bus.wr_data_stb) chk("io_data", io_data, m_rx_data);
      end
    end
  end

  // Serial decoder on txd, used for literal byte checks.
  logic [7:0] mon_b;
  logic [7:0] mon_bytes[$];
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.txd === 1'b0) begin
      repeat (CLK_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        mon_b[i] = bus.txd;
      end
      repeat (CLK_DIV) @(negedge clk);
      mon_bytes.push_back(mon_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_data(input logic [7:0] d, input int hold);
    tb_wdata = d;
    bus.wr_data_stb = 1'b1;
    repeat (hold) tick();
    bus.wr_data_stb = 1'b0;
    tick();
  endtask

  task automatic write_stat();
    tb_sdata = 8'hFF;
    bus.wr_stat_stb = 1'b1;
    tick();
    bus.wr_stat_stb = 1'b0;
    tick();
  endtask

  task automatic read_data();
    bus.rd_data_stb = 1'b1;
    tick();
    bus.rd_data_stb = 1'b0;
    tick();
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    rx_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.rxd = f[i];
      repeat (CLK_DIV) tick();
    end
    bus.rxd = 1'b1;
    repeat (2 * CLK_DIV) tick();
    if (!stop)             m_ferr = 1'b1;
    else if (!m_rx_valid)  begin m_rx_data = d; m_rx_valid = 1'b1; end
    else                   m_ovr = 1'b1;
    rx_active = 1'b0;
  endtask

  logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int f0;

  initial begin
    bus.wr_data_stb = 1'b0;
    bus.wr_stat_stb = 1'b0;
    bus.rd_data_stb = 1'b0;
    bus.rxd         = 1'b1;

    // Reset values
    repeat (2) tick();
    chk("rst_txd",  bus.txd, 8'd1);
    chk("rst_irq",  bus.irq, 8'd0);
    chk("rst_stat", io_stat, 8'h02);
    chk("rst_data", io_data, 8'h00);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Single byte 0xA5: start bit two edges after the strobe is raised
    f0 = frames;
    tb_wdata = 8'hA5;
    bus.wr_data_stb = 1'b1;
    tick();
    bus.wr_data_stb = 1'b0;
    chk("lat_txd_e0", bus.txd, 8'd1);
    tick();
    chk("lat_txd_e1", bus.txd, 8'd0);
    chk("lat_busy", io_stat[4], 8'd1);
    repeat (45) tick();
    chk("a5_count", 8'(mon_bytes.size()), 8'd1);
    if (mon_bytes.size() > 0) chk("a5_byte", mon_bytes[0], 8'hA5);
    chk("a5_frames", 8'(frames - f0), 8'd1);

    // Burst of 6: one in flight plus four queued, sixth dropped
    mon_bytes.delete();
    f0 = frames;
    full_seen = 1'b0;
    for (int k = 0; k < 6; k++) write_data(burst[k], 3);
    repeat (5 * 10 * CLK_DIV + 20) tick();
    chk("burst_count", 8'(mon_bytes.size()), 8'd5);
    for (int k = 0; k < 5; k++)
      if (k < mon_bytes.size()) chk("burst_byte", mon_bytes[k], burst[k]);
    chk("burst_full_seen", 8'(full_seen), 8'd1);
    chk("burst_frames", 8'(frames - f0), 8'd5);

    // Receive 0x3C, then pop it
    send_rx(8'h3C, 1'b1);
    chk("rx_3c_data", io_data, 8'h3C);
    chk("rx_3c_irq", bus.irq, 8'd1);
    read_data();
    chk("rx_pop_irq", bus.irq, 8'd0);
    chk("rx_pop_valid", io_stat[2], 8'd0);
    chk("rx_pop_keep", io_data, 8'h3C);

    // Overrun, framing error, then status-write clear
    send_rx(8'h81, 1'b1);
    send_rx(8'h7E, 1'b1);
    chk("ovr_flag", io_stat[3], 8'd1);
    chk("ovr_keep", io_data, 8'h81);
    send_rx(8'hC3, 1'b0);
    chk("ferr_flag", io_stat[5], 8'd1);
    write_stat();
    chk("clr_errs", io_stat & 8'h28, 8'h00);
    chk("clr_valid_kept", io_stat[2], 8'd1);
    read_data();

    // Reset in the middle of a transmit data bit
    write_data(8'h5A, 1);
    repeat (2 * CLK_DIV + 2) tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid_txd", bus.txd, 8'd1);
    chk("rst_mid_stat", io_stat, 8'h02);
    rst_n = 1'b1;
    repeat (50) tick();

    // Two-cycle low glitch on rxd is a false start
    bus.rxd = 1'b0;
    repeat (2) tick();
    bus.rxd = 1'b1;
    repeat (20) tick();
    chk("glitch_valid", io_stat[2], 8'd0);
    chk("glitch_irq", bus.irq, 8'd0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
